// File: rtl/tc_pkg.sv
// Timer/counter shared definitions: FSM states, register word offsets,
// CTRL bit positions and MODE codes.
package tc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_CNT  = 2'b10,
    S_INT  = 2'b11
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'b00;
  localparam logic [1:0] A_PRESET = 2'b01;
  localparam logic [1:0] A_COUNT  = 2'b10;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/tc_prescaler.sv
// Mod-DIV tick generator: clk, reset, run -> tick (one clk pulse every DIV
// clocks while run=1; the phase restarts whenever run drops).
module tc_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || !run || tick) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped timer: CTRL/PRESET/COUNT words, load-decrement-interrupt FSM.
// Ports: clk, reset (sync, high), addr[1:0], we, wd[31:0] -> rd[31:0], irq.
// Macro TC_PRESCALE_EN: COUNT steps only every PRESCALE_DIV clocks.
module timer_counter
  import tc_pkg::*;
#(
  parameter int PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  state_t      state, state_n;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count, count_n;
  logic        flag;
  logic        tick;
  logic        set_flag, clr_flag, clr_en;

  logic en, reload, wr_ctrl, wr_preset;

  assign en        = ctrl[CTRL_EN];
  assign reload    = ctrl[CTRL_MODE+:2] == MODE_RELOAD;
  assign wr_ctrl   = we && (addr == A_CTRL);
  assign wr_preset = we && (addr == A_PRESET);

`ifdef TC_PRESCALE_EN
  tc_prescaler #(
    .DIV (PRESCALE_DIV)
  ) u_pre (
    .clk   (clk),
    .reset (reset),
    .run   (state == S_CNT),
    .tick  (tick)
  );
`else
  logic unused_div;
  assign unused_div = ^PRESCALE_DIV;
  assign tick = 1'b1;
`endif

  always_comb begin
    state_n  = state;
    count_n  = count;
    set_flag = 1'b0;
    clr_flag = 1'b0;
    clr_en   = 1'b0;
    unique case (state)
      S_IDLE: if (en) state_n = S_LOAD;
      S_LOAD: begin
        if (!en) state_n = S_IDLE;
        else begin
          count_n = preset;
          state_n = S_CNT;
        end
      end
      S_CNT: begin
        if (!en) state_n = S_IDLE;
        else if (tick) begin
          if (count > 32'd1) count_n = count - 32'd1;
          else begin
            count_n  = '0;
            set_flag = 1'b1;
            state_n  = S_INT;
          end
        end
      end
      S_INT: begin
        // Auto-reload goes straight back to LOAD so the period is PRESET+2.
        if (reload) begin
          clr_flag = 1'b1;
          state_n  = en ? S_LOAD : S_IDLE;
        end else begin
          clr_en  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
      flag   <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      if (wr_ctrl)     ctrl          <= wd[3:0];
      else if (clr_en) ctrl[CTRL_EN] <= 1'b0;
      if (wr_preset) preset <= wd;
      // Bus writes clear the flag ahead of any FSM set.
      if (wr_ctrl || wr_preset) flag <= 1'b0;
      else if (set_flag)        flag <= 1'b1;
      else if (clr_flag)        flag <= 1'b0;
    end
  end

  always_comb begin
    rd = '0;
    unique case (addr)
      A_CTRL:   rd = {28'b0, ctrl};
      A_PRESET: rd = preset;
      A_COUNT:  rd = count;
      default:  rd = '0;
    endcase
  end

  assign irq = flag && ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register access, one-shot, auto-reload,
// masked irq, stop/freeze, PRESET=0, and the prescaled build.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int errs = 0;
  int checks = 0;

  timer_counter #(.PRESCALE_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write lands on the next posedge (edge E0); returns at E0+1.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    we   = 1'b1;
    wd   = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rdw(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd;
  endtask

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] v;

  initial begin
    reset = 1'b1;
    addr  = 2'b00;
    we    = 1'b0;
    wd    = '0;
    edge_n(2);
    for (int a = 0; a < 4; a++) begin
      rdw(2'(a), v);
      chk($sformatf("rst_rd%0d", a), v, 32'h0);
    end
    chk("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

`ifdef TC_PRESCALE_EN
    // Prescaled: PRESET=2, DIV=4 -> flag at E10.
    wr(2'b01, 32'd2);
    wr(2'b00, 32'h9);
    edge_n(2);
    rdw(2'b10, v); chk("ps_e2", v, 32'd2);
    edge_n(3);
    rdw(2'b10, v); chk("ps_e5", v, 32'd2);
    edge_n(1);
    rdw(2'b10, v); chk("ps_e6", v, 32'd1);
    edge_n(3);
    rdw(2'b10, v); chk("ps_e9", v, 32'd1);
    chk("ps_irq_e9", {31'b0, irq}, 32'h0);
    edge_n(1);
    rdw(2'b10, v); chk("ps_e10", v, 32'd0);
    chk("ps_irq_e10", {31'b0, irq}, 32'h1);
    edge_n(1);
    rdw(2'b00, v); chk("ps_ctrl", v, 32'h8);
`else
    // One-shot, PRESET=3.
    wr(2'b01, 32'd3);
    rdw(2'b01, v); chk("preset_rd", v, 32'd3);
    wr(2'b00, 32'h9);
    edge_n(2);
    rdw(2'b10, v); chk("os_e2", v, 32'd3);
    edge_n(1);
    rdw(2'b10, v); chk("os_e3", v, 32'd2);
    edge_n(1);
    rdw(2'b10, v); chk("os_e4", v, 32'd1);
    chk("os_irq_e4", {31'b0, irq}, 32'h0);
    edge_n(1);
    rdw(2'b10, v); chk("os_e5", v, 32'd0);
    chk("os_irq_e5", {31'b0, irq}, 32'h1);
    edge_n(1);
    rdw(2'b00, v); chk("os_ctrl_e6", v, 32'h8);
    chk("os_irq_e6", {31'b0, irq}, 32'h1);
    edge_n(2);
    chk("os_irq_hold", {31'b0, irq}, 32'h1);
    rdw(2'b11, v); chk("rd_unused", v, 32'h0);
    wr(2'b01, 32'd3);
    chk("os_irq_clr", {31'b0, irq}, 32'h0);

    // Auto-reload, PRESET=2: pulses at E4, E8, E12.
    wr(2'b01, 32'd2);
    wr(2'b00, 32'hB);
    for (int e = 1; e <= 13; e++) begin
      edge_n(1);
      chk($sformatf("ar_irq_e%0d", e), {31'b0, irq},
          {31'b0, (e == 4 || e == 8 || e == 12)});
    end
    rdw(2'b00, v); chk("ar_ctrl", v, 32'hB);
    wr(2'b00, 32'h0);
    edge_n(3);
    chk("ar_stop_irq", {31'b0, irq}, 32'h0);

    // Masked: PRESET=3, IM=0.
    wr(2'b01, 32'd3);
    wr(2'b00, 32'h1);
    edge_n(5);
    rdw(2'b10, v); chk("im0_cnt", v, 32'd0);
    chk("im0_irq_e5", {31'b0, irq}, 32'h0);
    edge_n(1);
    rdw(2'b00, v); chk("im0_ctrl", v, 32'h0);
    chk("im0_irq_e6", {31'b0, irq}, 32'h0);

    // Stop mid-count: COUNT becomes 5 at E7 as EN is cleared.
    wr(2'b01, 32'd10);
    wr(2'b00, 32'h9);
    edge_n(6);
    rdw(2'b10, v); chk("stop_e6", v, 32'd6);
    wr(2'b00, 32'h8);
    rdw(2'b10, v); chk("stop_e7", v, 32'd5);
    edge_n(4);
    rdw(2'b10, v); chk("stop_frozen", v, 32'd5);
    chk("stop_irq", {31'b0, irq}, 32'h0);
    wr(2'b10, 32'h77);
    edge_n(1);
    rdw(2'b10, v); chk("count_ro", v, 32'd5);
    rdw(2'b00, v); chk("stop_ctrl", v, 32'h8);

    // PRESET=0 behaves as PRESET=1: flag at E3.
    wr(2'b01, 32'd0);
    wr(2'b00, 32'h9);
    edge_n(2);
    chk("p0_irq_e2", {31'b0, irq}, 32'h0);
    edge_n(1);
    rdw(2'b10, v); chk("p0_cnt", v, 32'd0);
    chk("p0_irq_e3", {31'b0, irq}, 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
